// File: rtl/rename_reg_file_pkg.sv
// Shared types and sizing for the rename/status register file and its checkpoint bank.
package rename_reg_file_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int REG_W    = $clog2(NREG);
  localparam int TAG_W    = 4;
  localparam int ISSUE_W  = 2;
  localparam int COMMIT_W = 2;
  localparam int NCKPT    = 4;
  localparam int CK_W     = $clog2(NCKPT);

  typedef logic [REG_W-1:0] reg_id_t;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]  word_t;

  // Whole-table image of pending tags, one entry per architectural register.
  typedef logic [NREG-1:0][TAG_W-1:0] tag_img_t;

  localparam rob_tag_t NONE_TAG = '0;

  // Clears every entry of a tag image that matches a tag committing this cycle.
  // Tags are unique in flight, so no register-id compare is needed.
  function automatic tag_img_t clearCommitted(
    input tag_img_t                    img,
    input logic [COMMIT_W-1:0]         cmtValid,
    input logic [COMMIT_W*REG_W-1:0]   cmtRd,
    input logic [COMMIT_W*TAG_W-1:0]   cmtTag
  );
    tag_img_t res;
    res = img;
    for (int r = 0; r < NREG; r++) begin
      for (int c = 0; c < COMMIT_W; c++) begin
        if (cmtValid[c] && (cmtRd[c*REG_W +: REG_W] != '0) &&
            (img[r] == cmtTag[c*TAG_W +: TAG_W])) begin
          res[r] = NONE_TAG;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rename_reg_file_ckpt.sv
// Checkpoint bank: holds rename-table snapshots, their valid bits and the free-slot allocator.
module rename_ckpt_bank
  import rename_reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy_i,
  input  logic                      flush_i,
  input  logic                      save_i,
  input  tag_img_t                  save_img_i,
  input  logic                      restore_i,
  input  logic [CK_W-1:0]           restore_id_i,
  input  logic [NCKPT-1:0]          kill_mask_i,
  input  logic                      free_i,
  input  logic [CK_W-1:0]           free_id_i,
  input  logic [COMMIT_W-1:0]       cmt_valid_i,
  input  logic [COMMIT_W*REG_W-1:0] cmt_rd_i,
  input  logic [COMMIT_W*TAG_W-1:0] cmt_tag_i,
  output logic [CK_W-1:0]           alloc_id_o,
  output logic                      full_o,
  output tag_img_t                  restore_img_o
);

  tag_img_t            ckTab_q [NCKPT];
  tag_img_t            ckTab_d [NCKPT];
  logic [NCKPT-1:0]    ckVld_q;
  logic [NCKPT-1:0]    ckVld_d;

  assign full_o = &ckVld_q;

  // Lowest-index free checkpoint; scanning downward lets the lowest index win.
  always_comb begin
    alloc_id_o = '0;
    for (int k = NCKPT - 1; k >= 0; k--) begin
      if (!ckVld_q[k]) alloc_id_o = CK_W'(k);
    end
  end

  // Restored image already has this cycle's commits removed.
  always_comb begin
    restore_img_o = clearCommitted(ckTab_q[restore_id_i], cmt_valid_i, cmt_rd_i, cmt_tag_i);
  end

  // Next-state for snapshots: flush drops all, restore kills, otherwise free then save.
  always_comb begin
    ckVld_d = ckVld_q;
    for (int k = 0; k < NCKPT; k++) begin
      ckTab_d[k] = clearCommitted(ckTab_q[k], cmt_valid_i, cmt_rd_i, cmt_tag_i);
    end
    if (flush_i) begin
      ckVld_d = '0;
      for (int k = 0; k < NCKPT; k++) ckTab_d[k] = ckTab_q[k];
    end else if (restore_i) begin
      ckVld_d = ckVld_q & ~kill_mask_i;
      if (free_i) ckVld_d[free_id_i] = 1'b0;
    end else begin
      if (free_i) ckVld_d[free_id_i] = 1'b0;
      if (save_i && !full_o) begin
        ckTab_d[alloc_id_o] = save_img_i;
        ckVld_d[alloc_id_o] = 1'b1;
      end
    end
  end

  // Snapshot state registers, held while the pipeline is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      ckVld_q <= '0;
      for (int k = 0; k < NCKPT; k++) ckTab_q[k] <= '0;
    end else if (rdy_i) begin
      ckVld_q <= ckVld_d;
      for (int k = 0; k < NCKPT; k++) ckTab_q[k] <= ckTab_d[k];
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Superscalar register file with per-register pending ROB tags, bundle bypass and checkpoints.
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [ISSUE_W-1:0]        iss_valid,
  input  logic [ISSUE_W*REG_W-1:0]  iss_rs1,
  input  logic [ISSUE_W*REG_W-1:0]  iss_rs2,
  input  logic [ISSUE_W*REG_W-1:0]  iss_rd,
  input  logic [ISSUE_W*TAG_W-1:0]  iss_tag,
  output logic [ISSUE_W*XLEN-1:0]   iss_vj,
  output logic [ISSUE_W*XLEN-1:0]   iss_vk,
  output logic [ISSUE_W*TAG_W-1:0]  iss_qj,
  output logic [ISSUE_W*TAG_W-1:0]  iss_qk,
  input  logic [COMMIT_W-1:0]       cmt_valid,
  input  logic [COMMIT_W*REG_W-1:0] cmt_rd,
  input  logic [COMMIT_W*TAG_W-1:0] cmt_tag,
  input  logic [COMMIT_W*XLEN-1:0]  cmt_value,
  input  logic                      flush,
  input  logic                      ck_save,
  output logic [CK_W-1:0]           ck_alloc_id,
  output logic                      ck_full,
  input  logic                      ck_restore,
  input  logic [CK_W-1:0]           ck_restore_id,
  input  logic [NCKPT-1:0]          ck_kill_mask,
  input  logic                      ck_free,
  input  logic [CK_W-1:0]           ck_free_id
);

  word_t    values_q [NREG];
  word_t    values_d [NREG];
  tag_img_t status_q;
  tag_img_t status_d;
  tag_img_t restoreImg;

  rename_ckpt_bank u_ckpt (
    .clk           (clk),
    .rst           (rst),
    .rdy_i         (rdy),
    .flush_i       (flush),
    .save_i        (ck_save),
    .save_img_i    (status_d),
    .restore_i     (ck_restore),
    .restore_id_i  (ck_restore_id),
    .kill_mask_i   (ck_kill_mask),
    .free_i        (ck_free),
    .free_id_i     (ck_free_id),
    .cmt_valid_i   (cmt_valid),
    .cmt_rd_i      (cmt_rd),
    .cmt_tag_i     (cmt_tag),
    .alloc_id_o    (ck_alloc_id),
    .full_o        (ck_full),
    .restore_img_o (restoreImg)
  );

  // Operand lookup: older bundle slot, then committing value, then pending tag, then stored value.
  always_comb begin
    reg_id_t  src;
    rob_tag_t q;
    word_t    v;
    word_t    cmtVal;
    logic     hitBundle;
    logic     hitCmt;
    src = '0; q = NONE_TAG; v = '0; cmtVal = '0; hitBundle = 1'b0; hitCmt = 1'b0;
    iss_qj = '0; iss_qk = '0; iss_vj = '0; iss_vk = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? iss_rs1[i*REG_W +: REG_W] : iss_rs2[i*REG_W +: REG_W];
        q = NONE_TAG; v = '0; cmtVal = '0; hitBundle = 1'b0; hitCmt = 1'b0;
        if (src != '0) begin
          for (int j = 0; j < i; j++) begin
            if (iss_valid[j] && (iss_rd[j*REG_W +: REG_W] == src)) begin
              hitBundle = 1'b1;
              q = iss_tag[j*TAG_W +: TAG_W];
            end
          end
          for (int c = 0; c < COMMIT_W; c++) begin
            if (cmt_valid[c] && (cmt_rd[c*REG_W +: REG_W] == src) &&
                (cmt_tag[c*TAG_W +: TAG_W] == status_q[src])) begin
              hitCmt = 1'b1;
              cmtVal = cmt_value[c*XLEN +: XLEN];
            end
          end
          if (!hitBundle) begin
            if (hitCmt) v = cmtVal;
            else if (status_q[src] != NONE_TAG) q = status_q[src];
            else v = values_q[src];
          end
        end
        if (s == 0) begin
          iss_qj[i*TAG_W +: TAG_W] = q;
          iss_vj[i*XLEN +: XLEN] = v;
        end else begin
          iss_qk[i*TAG_W +: TAG_W] = q;
          iss_vk[i*XLEN +: XLEN] = v;
        end
      end
    end
  end

  // Next architectural state in priority order flush > restore > normal commit/issue.
  always_comb begin
    reg_id_t rd;
    rd = '0;
    values_d = values_q;
    status_d = status_q;
    if (flush) begin
      status_d = '0;
    end else begin
      for (int c = 0; c < COMMIT_W; c++) begin
        rd = cmt_rd[c*REG_W +: REG_W];
        if (cmt_valid[c] && (rd != '0)) values_d[rd] = cmt_value[c*XLEN +: XLEN];
      end
      if (ck_restore) begin
        status_d = restoreImg;
      end else begin
        for (int c = 0; c < COMMIT_W; c++) begin
          rd = cmt_rd[c*REG_W +: REG_W];
          if (cmt_valid[c] && (rd != '0) && (status_q[rd] == cmt_tag[c*TAG_W +: TAG_W])) begin
            status_d[rd] = NONE_TAG;
          end
        end
        for (int i = 0; i < ISSUE_W; i++) begin
          rd = iss_rd[i*REG_W +: REG_W];
          if (iss_valid[i] && (rd != '0)) status_d[rd] = iss_tag[i*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Value and status registers, held while the pipeline is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      for (int r = 0; r < NREG; r++) values_q[r] <= '0;
    end else if (rdy) begin
      status_q <= status_d;
      for (int r = 0; r < NREG; r++) values_q[r] <= values_d[r];
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench: stimulus queues expected outputs, a monitor compares them mid-cycle.
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rdy;
  logic [ISSUE_W-1:0]        iss_valid;
  logic [ISSUE_W*REG_W-1:0]  iss_rs1, iss_rs2, iss_rd;
  logic [ISSUE_W*TAG_W-1:0]  iss_tag, iss_qj, iss_qk;
  logic [ISSUE_W*XLEN-1:0]   iss_vj, iss_vk;
  logic [COMMIT_W-1:0]       cmt_valid;
  logic [COMMIT_W*REG_W-1:0] cmt_rd;
  logic [COMMIT_W*TAG_W-1:0] cmt_tag;
  logic [COMMIT_W*XLEN-1:0]  cmt_value;
  logic                      flush, ck_save, ck_restore, ck_free, ck_full;
  logic [CK_W-1:0]           ck_alloc_id, ck_restore_id, ck_free_id;
  logic [NCKPT-1:0]          ck_kill_mask;

  typedef enum int {K_QJ0, K_VJ0, K_QJ1, K_VJ1, K_QK1, K_VK1, K_FULL, K_ALLOC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rename_reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .iss_valid     (iss_valid),
    .iss_rs1       (iss_rs1),
    .iss_rs2       (iss_rs2),
    .iss_rd        (iss_rd),
    .iss_tag       (iss_tag),
    .iss_vj        (iss_vj),
    .iss_vk        (iss_vk),
    .iss_qj        (iss_qj),
    .iss_qk        (iss_qk),
    .cmt_valid     (cmt_valid),
    .cmt_rd        (cmt_rd),
    .cmt_tag       (cmt_tag),
    .cmt_value     (cmt_value),
    .flush         (flush),
    .ck_save       (ck_save),
    .ck_alloc_id   (ck_alloc_id),
    .ck_full       (ck_full),
    .ck_restore    (ck_restore),
    .ck_restore_id (ck_restore_id),
    .ck_kill_mask  (ck_kill_mask),
    .ck_free       (ck_free),
    .ck_free_id    (ck_free_id)
  );

  task automatic clearInputs();
    rdy = 1'b1; iss_valid = '0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_tag = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_tag = '0; cmt_value = '0;
    flush = 1'b0; ck_save = 1'b0; ck_restore = 1'b0; ck_restore_id = '0;
    ck_kill_mask = '0; ck_free = 1'b0; ck_free_id = '0;
  endtask

  task automatic setIss(input int s, input reg_id_t rs1, input reg_id_t rs2,
                        input reg_id_t rd, input rob_tag_t tag, input logic v);
    iss_rs1[s*REG_W +: REG_W] = rs1;
    iss_rs2[s*REG_W +: REG_W] = rs2;
    iss_rd[s*REG_W +: REG_W]  = rd;
    iss_tag[s*TAG_W +: TAG_W] = tag;
    iss_valid[s]              = v;
  endtask

  task automatic setCmt(input int s, input reg_id_t rd, input rob_tag_t tag, input word_t val);
    cmt_rd[s*REG_W +: REG_W]    = rd;
    cmt_tag[s*TAG_W +: TAG_W]   = tag;
    cmt_value[s*XLEN +: XLEN]   = val;
    cmt_valid[s]                = 1'b1;
  endtask

  task automatic checkOutput(input kind_e k, input logic [31:0] e, input string n);
    exp_t x;
    x.kind = k; x.exp = e; x.name = n;
    expQ.push_back(x);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  // Monitor: mid-cycle, compare every queued expectation against the live outputs.
  initial begin
    exp_t        x;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        x = expQ.pop_front();
        case (x.kind)
          K_QJ0:   act = 32'(iss_qj[TAG_W-1:0]);
          K_VJ0:   act = iss_vj[XLEN-1:0];
          K_QJ1:   act = 32'(iss_qj[2*TAG_W-1:TAG_W]);
          K_VJ1:   act = iss_vj[2*XLEN-1:XLEN];
          K_QK1:   act = 32'(iss_qk[2*TAG_W-1:TAG_W]);
          K_VK1:   act = iss_vk[2*XLEN-1:XLEN];
          K_FULL:  act = 32'(ck_full);
          default: act = 32'(ck_alloc_id);
        endcase
        checks++;
        if (act !== x.exp) begin
          failures++;
          $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", x.name, act, x.exp);
        end
      end
    end
  end

  initial begin
    int drainWait;
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    setIss(0, 5'd5, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "rst_qj0"); checkOutput(K_VJ0, 0, "rst_vj0");
    checkOutput(K_QK1, 0, "rst_qk1"); checkOutput(K_VK1, 0, "rst_vk1");
    checkOutput(K_FULL, 0, "rst_full"); checkOutput(K_ALLOC, 0, "rst_alloc");
    applyStimulus();

    // Plain commit then read
    setCmt(0, 5'd3, 4'd0, 32'hAA);
    applyStimulus();
    setIss(0, 5'd3, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "r3_qj"); checkOutput(K_VJ0, 32'hAA, "r3_vj");
    applyStimulus();

    // Intra-bundle dependency, youngest rename wins
    setIss(0, 5'd0, 5'd0, 5'd4, 4'd2, 1'b1);
    setIss(1, 5'd4, 5'd0, 5'd4, 4'd3, 1'b1);
    checkOutput(K_QJ1, 2, "bundle_qj1"); checkOutput(K_VJ1, 0, "bundle_vj1");
    applyStimulus();
    setIss(0, 5'd4, 5'd0, 5'd0, 4'd0, 1'b0);
    setCmt(0, 5'd4, 4'd2, 32'h55);
    checkOutput(K_QJ0, 3, "r4_stale_cmt_qj");
    applyStimulus();
    setIss(0, 5'd4, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 3, "r4_still3_qj"); checkOutput(K_VJ0, 0, "r4_still3_vj");
    applyStimulus();

    // Commit bypass on the same cycle as the read
    setIss(0, 5'd0, 5'd0, 5'd6, 4'd5, 1'b1);
    applyStimulus();
    setCmt(0, 5'd6, 4'd5, 32'h11);
    setIss(0, 5'd6, 5'd0, 5'd0, 4'd0, 1'b0);
    setIss(1, 5'd0, 5'd6, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "r6_byp_qj"); checkOutput(K_VJ0, 32'h11, "r6_byp_vj");
    checkOutput(K_QK1, 0, "r6_byp_qk1"); checkOutput(K_VK1, 32'h11, "r6_byp_vk1");
    applyStimulus();
    setIss(0, 5'd6, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "r6_after_qj"); checkOutput(K_VJ0, 32'h11, "r6_after_vj");
    applyStimulus();

    // Two commits to the same register, highest slot wins
    setCmt(0, 5'd8, 4'd0, 32'h1);
    setCmt(1, 5'd8, 4'd0, 32'h2);
    setIss(0, 5'd8, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_VJ0, 32'h2, "r8_byp_vj");
    applyStimulus();
    setIss(0, 5'd8, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_VJ0, 32'h2, "r8_after_vj");
    applyStimulus();

    // rdy low holds all state
    rdy = 1'b0;
    setCmt(0, 5'd3, 4'd0, 32'h33);
    setIss(0, 5'd0, 5'd0, 5'd3, 4'd9, 1'b1);
    applyStimulus();
    setIss(0, 5'd3, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "hold_qj"); checkOutput(K_VJ0, 32'hAA, "hold_vj");
    applyStimulus();

    // Checkpoint save, rename again, commit old tag, restore
    checkOutput(K_ALLOC, 0, "ck_alloc0");
    setIss(0, 5'd0, 5'd0, 5'd7, 4'd1, 1'b1);
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_ALLOC, 1, "ck_alloc1"); checkOutput(K_FULL, 0, "ck_notfull");
    setIss(0, 5'd7, 5'd0, 5'd7, 4'd4, 1'b1);
    checkOutput(K_QJ0, 1, "r7_tag1_qj");
    applyStimulus();
    setCmt(0, 5'd7, 4'd1, 32'h77);
    setIss(0, 5'd7, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 4, "r7_tag4_qj"); checkOutput(K_VJ0, 0, "r7_tag4_vj");
    applyStimulus();
    ck_restore = 1'b1; ck_restore_id = 2'd0; ck_kill_mask = 4'b0001;
    applyStimulus();
    setIss(0, 5'd7, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "r7_rest_qj"); checkOutput(K_VJ0, 32'h77, "r7_rest_vj");
    checkOutput(K_ALLOC, 0, "rest_alloc"); checkOutput(K_FULL, 0, "rest_full");
    applyStimulus();

    // Fill all checkpoints, overflow save, free one, restore the first
    checkOutput(K_ALLOC, 0, "fill_alloc0");
    setIss(0, 5'd0, 5'd0, 5'd10, 4'd7, 1'b1);
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_ALLOC, 1, "fill_alloc1");
    setIss(0, 5'd0, 5'd0, 5'd10, 4'd8, 1'b1);
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_ALLOC, 2, "fill_alloc2");
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_ALLOC, 3, "fill_alloc3");
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_FULL, 1, "fill_full");
    ck_save = 1'b1;
    applyStimulus();
    checkOutput(K_FULL, 1, "over_full");
    ck_free = 1'b1; ck_free_id = 2'd2;
    applyStimulus();
    checkOutput(K_FULL, 0, "free_full"); checkOutput(K_ALLOC, 2, "free_alloc");
    setIss(0, 5'd10, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 8, "r10_pre_qj");
    ck_restore = 1'b1; ck_restore_id = 2'd0; ck_kill_mask = 4'b1111;
    applyStimulus();
    setIss(0, 5'd10, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 7, "r10_rest_qj");
    checkOutput(K_FULL, 0, "kill_full"); checkOutput(K_ALLOC, 0, "kill_alloc");
    applyStimulus();

    // Flush clears status and checkpoints but keeps values
    setCmt(0, 5'd9, 4'd0, 32'h99);
    applyStimulus();
    setIss(0, 5'd0, 5'd0, 5'd9, 4'd6, 1'b1);
    ck_save = 1'b1;
    applyStimulus();
    setIss(0, 5'd9, 5'd0, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 6, "r9_pend_qj"); checkOutput(K_ALLOC, 1, "pre_flush_alloc");
    flush = 1'b1;
    setCmt(0, 5'd12, 4'd0, 32'h5A);
    applyStimulus();
    setIss(0, 5'd9, 5'd0, 5'd0, 4'd0, 1'b0);
    setIss(1, 5'd4, 5'd12, 5'd0, 4'd0, 1'b0);
    checkOutput(K_QJ0, 0, "fl_r9_qj"); checkOutput(K_VJ0, 32'h99, "fl_r9_vj");
    checkOutput(K_QJ1, 0, "fl_r4_qj"); checkOutput(K_VJ1, 32'h55, "fl_r4_vj");
    checkOutput(K_VK1, 0, "fl_r12_vk");
    checkOutput(K_ALLOC, 0, "fl_alloc"); checkOutput(K_FULL, 0, "fl_full");
    applyStimulus();

    drainWait = 0;
    while (expQ.size() > 0 && drainWait < 20) begin
      @(posedge clk);
      drainWait++;
    end
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Superscalar successor of the single-issue register/rename-status file.
- Holds architectural values plus a per-register pending ROB tag, with tag 0 meaning "value ready".
- Serves ISSUE_W rename slots and COMMIT_W commit slots per cycle.
- Adds NCKPT rename-table checkpoints, so a branch mispredict restores renames without a full flush. Sits between issuer, ROB and branch unit.

Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count; REG_W = clog2(NREG)
- TAG_W, 4, ROB tag width; tag 0 reserved as "none"
- ISSUE_W, 2, rename slots per cycle, slot 0 oldest
- COMMIT_W, 2, commit slots per cycle, slot 0 oldest
- NCKPT, 4, checkpoint count; CK_W = clog2(NCKPT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low = hold all state
- iss_valid  in  ISSUE_W  slot valid
- iss_rs1, iss_rs2, iss_rd  in  ISSUE_W*REG_W  source/dest ids; rd=0 means no dest
- iss_tag  in  ISSUE_W*TAG_W  ROB tag assigned to the slot
- iss_vj, iss_vk  out  ISSUE_W*XLEN  operand values (combinational)
- iss_qj, iss_qk  out  ISSUE_W*TAG_W  pending tags (combinational)
- cmt_valid  in  COMMIT_W  commit valid
- cmt_rd  in  COMMIT_W*REG_W  commit destination
- cmt_tag  in  COMMIT_W*TAG_W  commit ROB tag
- cmt_value  in  COMMIT_W*XLEN  commit data
- flush  in  1  ROB-bus full flush
- ck_save  in  1  snapshot the rename table this cycle
- ck_alloc_id  out  CK_W  lowest free checkpoint id (combinational)
- ck_full  out  1  no free checkpoint
- ck_restore  in  1  mispredict: restore checkpoint ck_restore_id
- ck_restore_id  in  CK_W  checkpoint to restore
- ck_kill_mask  in  NCKPT  checkpoints to free with the restore (younger ones, plus the restored one)
- ck_free  in  1  branch resolved correctly: free ck_free_id
- ck_free_id  in  CK_W  checkpoint to free

Behaviour:
- State: values[NREG], status[NREG], ck_tab[NCKPT][NREG], ck_vld[NCKPT]. Register 0 is hardwired: value 0, status 0, never renamed or written.
- Priority per cycle: rst > !rdy (hold) > flush > ck_restore > normal.
- rst:
  - values, status and ck_vld cleared.
  - With no inputs active, every iss_q*/iss_v* reads 0; ck_full=0; ck_alloc_id=0.
- flush:
  - status and ck_vld cleared; values unchanged.
  - Commits, issues, save and free in that cycle are ignored.
- Normal-cycle commit, for each valid slot c with cmt_rd != 0:
  - values[rd] <= value; the highest c wins on the same rd.
  - status[rd] <= 0 only if status[rd] == cmt_tag and no issue slot renames rd this cycle.
  - Every valid checkpoint entry equal to cmt_tag is cleared the same way. Tags are unique, so no rd compare is needed.
- Normal-cycle issue, for each valid slot i with rd != 0: status[rd] <= iss_tag[i]. The highest i wins on the same rd; issue beats commit clear.
- Operand lookup for slot i, source r, in order:
  - r == 0 -> q=0, v=0.
  - Youngest slot j < i that is valid with rd_j == r -> q=tag_j, v=0. This is the intra-bundle dependency.
  - Any valid commit with rd == r and tag == status[r] -> q=0, v=cmt_value (highest c if several).
  - status[r] != 0 -> q=status[r], v=0.
  - Otherwise q=0, v=values[r].
  - Lookup ignores flush/restore. During a flush or restore cycle the issuer must not issue.
- ck_save (normal cycle, ck_full=0):
  - ck_tab[ck_alloc_id] <= the status image after this cycle's issue and commit updates.
  - ck_vld set. The branch must therefore be the last valid slot.
  - ck_save while ck_full is ignored; the issuer must stall.
- ck_restore:
  - status <= ck_tab[ck_restore_id], then this cycle's commits cleared from the restored image.
  - Commits still write values.
  - ck_vld &= ~ck_kill_mask.
  - Issue and ck_save are ignored; a simultaneous ck_free of an id not in the kill mask is honoured.
- ck_free: ck_vld[id] <= 0. Freeing an invalid id is a no-op.
- Save and free of the same id in one cycle: the save wins, because the freed slot is not allocated until the next cycle.
- ck_alloc_id is the lowest index with ck_vld=0. ck_full = &ck_vld.

Decomposition:
- Shared package:
  - XLEN, REG_W, TAG_W, NONE_TAG=0
  - typedefs reg_id_t, rob_tag_t, word_t
- One sub-module, rename_ckpt_bank, owns:
  - ck_tab and ck_vld
  - the lowest-free priority encoder
  - save/restore-read/kill/free logic
  - tag clearing on commit
- The top-level module owns values/status, the bypass network and the priority order.

Test Plan:
- Reset, then read r5 on slot 0 -> q=0, v=0; ck_full=0; ck_alloc_id=0.
- Commit rd=3, tag=0, value=0xAA, then next cycle read r3 -> q=0, v=0xAA.
- Same cycle: slot0 rd=4 tag=2; slot1 rs1=4, rd=4, tag=3 -> slot1 qj=2. Next cycle status[4]=3. Commit tag 2 -> status[4] stays 3.
- Rename r6 to tag 5, then in the same cycle commit rd=6 tag=5 value=0x11 and read r6 -> q=0, v=0x11; next cycle status[6]=0.
- Issue rd=7 tag=1 with ck_save (id 0); then rd=7 tag=4; commit tag 1; restore id 0 with kill mask 0001 -> status[7]=0, values[7]=committed value, ck_vld=0000.
- Save 4 times -> ck_full=1 and a 5th save is ignored. ck_free id 2 -> ck_alloc_id=2. Flush -> all status 0, ck_vld 0, values kept.
